// File: rtl/bsg_link_upstream_sched.sv
// bsg_link_upstream_sched
//
// Credit-based round-robin scheduler that feeds the upstream DDR link.
// Several core-side requesters compete for one registered output word.
// A word is issued only while a downstream credit is available, and token
// pulses from the credit-return path replenish the credits.
//
// Ports
//   clk_i          core clock
//   reset_n_i      asynchronous active-low reset
//   req_v_i        per-requester valid
//   req_data_i     requester words, requester i at [i*width_p +: width_p]
//   req_yumi_o     one-hot accept pulse (combinational)
//   link_v_o       registered valid toward the link
//   link_data_o    registered data word
//   link_src_o     index of the requester whose word is held
//   link_ready_i   link accepts the held word
//   token_i        single-cycle credit token pulse (already synchronized)
//   credits_o      current credit count
//   credit_err_o   sticky credit-overflow flag
//   idle_o         no word held and all credits home
//
// Output stage FSM
//   state    | meaning
//   ST_EMPTY | no word held, link_v_o = 0
//   ST_FULL  | word held in link_data_o/link_src_o, link_v_o = 1

module bsg_link_upstream_sched #(
    parameter  int num_req_p       = 2,
    parameter  int width_p         = 64,
    parameter  int credits_p       = 16,
    parameter  int token_credits_p = 8,
    localparam int src_w_lp        = $clog2(num_req_p),
    localparam int cred_w_lp       = $clog2(credits_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [num_req_p-1:0]         req_v_i,
    input  logic [num_req_p*width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]         req_yumi_o,
    output logic                         link_v_o,
    output logic [width_p-1:0]           link_data_o,
    output logic [src_w_lp-1:0]          link_src_o,
    input  logic                         link_ready_i,
    input  logic                         token_i,
    output logic [cred_w_lp-1:0]         credits_o,
    output logic                         credit_err_o,
    output logic                         idle_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Credit arithmetic carries one guard bit so token overflow is visible.
    localparam logic [cred_w_lp:0]   cred_max_lp  = (cred_w_lp+1)'(credits_p);
    localparam logic [cred_w_lp:0]   cred_tok_lp  = (cred_w_lp+1)'(token_credits_p);
    localparam logic [cred_w_lp-1:0] cred_full_lp = cred_w_lp'(credits_p);

    state_e                 state_r, state_n;
    logic [src_w_lp-1:0]    last_r;
    logic [width_p-1:0]     data_r;
    logic [src_w_lp-1:0]    src_r;
    logic [cred_w_lp-1:0]   credits_r;
    logic                   credit_err_r;

    logic [src_w_lp-1:0]    winner;
    logic [src_w_lp-1:0]    idx;
    logic                   any_v;
    logic                   can_load;
    logic                   load;
    logic [cred_w_lp:0]     cred_sum;
    logic                   cred_over;
    logic [cred_w_lp-1:0]   cred_n;

    // Round-robin search from last_r+1. Scanning from the farthest candidate
    // down to the nearest lets the nearest valid requester overwrite the rest.
    always_comb begin
        winner = last_r;
        any_v  = 1'b0;
        idx    = '0;
        for (int k = num_req_p; k >= 1; k--) begin
            idx = src_w_lp'((int'(last_r) + k) % num_req_p);
            if (req_v_i[idx]) begin
                winner = idx;
                any_v  = 1'b1;
            end
        end
    end

    // The stage can take a new word when empty, or when the held word leaves
    // this cycle (zero-bubble). Gating uses the registered credit count only.
    assign can_load = (state_r == ST_EMPTY) || link_ready_i;
    assign load     = reset_n_i && any_v && (credits_r != '0) && can_load;

    always_comb begin
        req_yumi_o = '0;
        if (load) begin
            req_yumi_o = num_req_p'(1) << winner;
        end
    end

    always_comb begin
        state_n = state_r;
        if (load) begin
            state_n = ST_FULL;
        end else if ((state_r == ST_FULL) && link_ready_i) begin
            state_n = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_r <= '0;
            src_r  <= '0;
            last_r <= src_w_lp'(num_req_p - 1);
        end else if (load) begin
            data_r <= req_data_i[winner*width_p +: width_p];
            src_r  <= winner;
            last_r <= winner;
        end
    end

    // Credits are spent at load; a token adds token_credits_p. Anything above
    // the ceiling is clamped and latched as an error.
    always_comb begin
        cred_sum  = {1'b0, credits_r} - (cred_w_lp+1)'(load)
                    + (token_i ? cred_tok_lp : '0);
        cred_over = (cred_sum > cred_max_lp);
        cred_n    = cred_over ? cred_full_lp : cred_sum[cred_w_lp-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_r    <= cred_full_lp;
            credit_err_r <= 1'b0;
        end else begin
            credits_r    <= cred_n;
            credit_err_r <= credit_err_r | cred_over;
        end
    end

    assign link_v_o     = (state_r == ST_FULL);
    assign link_data_o  = data_r;
    assign link_src_o   = src_r;
    assign credits_o    = credits_r;
    assign credit_err_o = credit_err_r;
    assign idle_o       = (state_r == ST_EMPTY) && (credits_r == cred_full_lp);

endmodule

// File: tb/tb_bsg_link_upstream_sched.sv
module tb_bsg_link_upstream_sched;

    localparam int N    = 2;
    localparam int W    = 64;
    localparam int CRED = 16;
    localparam int TOK  = 8;
    localparam int SW   = $clog2(N);
    localparam int CW   = $clog2(CRED + 1);

    localparam logic [W-1:0] DATA_A = 64'hAAAA_0000_1111_0001;
    localparam logic [W-1:0] DATA_B = 64'hBBBB_0000_2222_0002;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_v = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_yumi;
    logic           link_v;
    logic [W-1:0]   link_data;
    logic [SW-1:0]  link_src;
    logic           link_ready = 1'b0;
    logic           token = 1'b0;
    logic [CW-1:0]  credits;
    logic           credit_err;
    logic           idle;

    int checks = 0;
    int failures = 0;

    // Reference model: output word, credit count, round-robin pointer.
    int           m_cred;
    int           m_last;
    int           m_src;
    bit           m_v;
    bit           m_err;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    bsg_link_upstream_sched #(
        .num_req_p       (N),
        .width_p         (W),
        .credits_p       (CRED),
        .token_credits_p (TOK)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_v_i      (req_v),
        .req_data_i   (req_data),
        .req_yumi_o   (req_yumi),
        .link_v_o     (link_v),
        .link_data_o  (link_data),
        .link_src_o   (link_src),
        .link_ready_i (link_ready),
        .token_i      (token),
        .credits_o    (credits),
        .credit_err_o (credit_err),
        .idle_o       (idle)
    );

    function automatic void model_reset();
        m_cred = CRED;
        m_last = N - 1;
        m_v    = 1'b0;
        m_err  = 1'b0;
        m_src  = 0;
        m_data = '0;
    endfunction

    // Requester accepted this cycle according to the rules, or -1.
    function automatic int exp_winner();
        if (!reset_n || m_cred == 0 || (m_v && !link_ready)) return -1;
        for (int k = 1; k <= N; k++) begin
            int i = (m_last + k) % N;
            if (req_v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_yumi();
        int w = exp_winner();
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    // Advance one clock edge and update the model with the inputs seen there.
    task automatic advance();
        int             w   = exp_winner();
        bit             tok = token;
        bit             rdy = link_ready;
        logic [N*W-1:0] d   = req_data;
        int             c;
        @(posedge clk);
        if (w >= 0) begin
            m_v    = 1'b1;
            m_data = d[w*W +: W];
            m_src  = w;
            m_last = w;
        end else if (m_v && rdy) begin
            m_v = 1'b0;
        end
        c = m_cred - ((w >= 0) ? 1 : 0) + (tok ? TOK : 0);
        if (c > CRED) begin
            c     = CRED;
            m_err = 1'b1;
        end
        m_cred = c;
        #1;
    endtask

    task automatic do_reset();
        req_v      = '0;
        token      = 1'b0;
        link_ready = 1'b0;
        reset_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_v      = '1;
        link_ready = 1'b1;
        token      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (credits !== CW'(CRED)) begin failures++; $display("FAIL reset_credits got=%0d exp=%0d", credits, CRED); end
        checks++; if (link_v !== 1'b0) begin failures++; $display("FAIL reset_link_v got=%b exp=0", link_v); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
        checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", credit_err); end
        checks++; if (req_yumi !== '0) begin failures++; $display("FAIL reset_yumi got=%b exp=0", req_yumi); end
        checks++; if (link_data !== '0 || link_src !== '0) begin failures++; $display("FAIL reset_data got=%h/%0d exp=0/0", link_data, link_src); end
        req_v   = '0;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_credit_exhaust();
        int n_yumi = 0;
        int first  = -1;
        do_reset();
        req_data   = {DATA_B, DATA_A};
        req_v      = 2'b01;
        link_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic [N-1:0] e = (cyc < 16) ? 2'b01 : 2'b00;
            #1;
            checks++; if (req_yumi !== e) begin failures++; $display("FAIL exhaust_yumi cyc=%0d got=%b exp=%b", cyc, req_yumi, e); end
            if (req_yumi != '0) n_yumi++;
            advance();
        end
        checks++; if (n_yumi != 16) begin failures++; $display("FAIL exhaust_count got=%0d exp=16", n_yumi); end
        checks++; if (credits !== '0) begin failures++; $display("FAIL exhaust_credits got=%0d exp=0", credits); end
        token = 1'b1;
        #1;
        checks++; if (req_yumi !== '0) begin failures++; $display("FAIL token_same_cycle_yumi got=%b exp=0", req_yumi); end
        advance();
        token  = 1'b0;
        n_yumi = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (req_yumi != '0) begin
                n_yumi++;
                if (first < 0) first = cyc;
            end
            advance();
        end
        checks++; if (n_yumi != 8) begin failures++; $display("FAIL restore_count got=%0d exp=8", n_yumi); end
        checks++; if (first != 0) begin failures++; $display("FAIL restore_first got=%0d exp=0", first); end
        checks++; if (credits !== '0) begin failures++; $display("FAIL restore_credits got=%0d exp=0", credits); end
    endtask

    task automatic test_round_robin();
        int prev = -1;
        do_reset();
        req_data   = {DATA_B, DATA_A};
        req_v      = 2'b11;
        link_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int           w = i % 2;
            logic [N-1:0] e = N'(1) << w;
            #1;
            checks++; if (req_yumi !== e) begin failures++; $display("FAIL rr_yumi i=%0d got=%b exp=%b", i, req_yumi, e); end
            if (prev >= 0) begin
                checks++;
                if (link_v !== 1'b1 || link_src !== SW'(prev) || link_data !== ((prev == 1) ? DATA_B : DATA_A)) begin
                    failures++;
                    $display("FAIL rr_link i=%0d got=%b/%0d/%h exp=1/%0d", i, link_v, link_src, link_data, prev);
                end
            end
            prev = w;
            advance();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_data   = {DATA_B, DATA_A};
        req_v      = 2'b11;
        link_ready = 1'b1;
        #1;
        checks++; if (req_yumi !== 2'b01) begin failures++; $display("FAIL bp_first_yumi got=%b exp=01", req_yumi); end
        advance();
        link_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (req_yumi !== '0 || link_v !== 1'b1 || link_data !== DATA_A || link_src !== '0 || credits !== CW'(15)) begin
                failures++;
                $display("FAIL bp_stall i=%0d got yumi=%b v=%b data=%h src=%0d cred=%0d exp 0/1/%h/0/15",
                         i, req_yumi, link_v, link_data, link_src, credits, DATA_A);
            end
            advance();
        end
        link_ready = 1'b1;
        #1;
        checks++; if (req_yumi !== 2'b10) begin failures++; $display("FAIL bp_release_yumi got=%b exp=10", req_yumi); end
        advance();
        checks++;
        if (link_v !== 1'b1 || link_data !== DATA_B || link_src !== SW'(1) || credits !== CW'(14)) begin
            failures++;
            $display("FAIL bp_release_link got v=%b data=%h src=%0d cred=%0d exp 1/%h/1/14", link_v, link_data, link_src, credits, DATA_B);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_data   = {DATA_B, DATA_A};
        req_v      = 2'b01;
        link_ready = 1'b1;
        repeat (13) advance();
        #1;
        checks++; if (credits !== CW'(3)) begin failures++; $display("FAIL simul_pre_credits got=%0d exp=3", credits); end
        token = 1'b1;
        #1;
        checks++; if (req_yumi !== 2'b01) begin failures++; $display("FAIL simul_yumi got=%b exp=01", req_yumi); end
        advance();
        token = 1'b0;
        checks++; if (credits !== CW'(10)) begin failures++; $display("FAIL simul_credits got=%0d exp=10", credits); end
    endtask

    task automatic test_overflow();
        do_reset();
        token = 1'b1;
        advance();
        token = 1'b0;
        checks++; if (credits !== CW'(CRED) || credit_err !== 1'b1) begin failures++; $display("FAIL ovf_set got cred=%0d err=%b exp 16/1", credits, credit_err); end
        repeat (5) advance();
        checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", credit_err); end
        reset_n = 1'b0;
        #1;
        checks++; if (credit_err !== 1'b0 || credits !== CW'(CRED)) begin failures++; $display("FAIL ovf_clear got err=%b cred=%0d exp 0/16", credit_err, credits); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_data   = {DATA_B, DATA_A};
        req_v      = 2'b11;
        link_ready = 1'b1;
        repeat (5) advance();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (link_v !== 1'b0 || credits !== CW'(CRED) || idle !== 1'b1 || req_yumi !== '0 || credit_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset got v=%b cred=%0d idle=%b yumi=%b err=%b exp 0/16/1/0/0", link_v, credits, idle, req_yumi, credit_err);
        end
        @(posedge clk);
        #1;
        req_v   = '0;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int tok_pct = (cyc < 200) ? 10 : 30;
            req_v = N'($urandom);
            for (int i = 0; i < N*W/32; i++) req_data[i*32 +: 32] = $urandom;
            link_ready = ($urandom_range(0, 9) < 7);
            token      = ($urandom_range(0, 99) < tok_pct);
            #1;
            checks++; if (req_yumi !== exp_yumi()) begin failures++; $display("FAIL rand_yumi cyc=%0d got=%b exp=%b", cyc, req_yumi, exp_yumi()); end
            checks++; if (link_v !== m_v) begin failures++; $display("FAIL rand_link_v cyc=%0d got=%b exp=%b", cyc, link_v, m_v); end
            if (m_v) begin
                checks++;
                if (link_data !== m_data || link_src !== SW'(m_src)) begin
                    failures++;
                    $display("FAIL rand_word cyc=%0d got=%h/%0d exp=%h/%0d", cyc, link_data, link_src, m_data, m_src);
                end
            end
            checks++; if (credits !== CW'(m_cred)) begin failures++; $display("FAIL rand_credits cyc=%0d got=%0d exp=%0d", cyc, credits, m_cred); end
            checks++; if (credit_err !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, credit_err, m_err); end
            checks++; if (idle !== (!m_v && m_cred == CRED)) begin failures++; $display("FAIL rand_idle cyc=%0d got=%b exp=%b", cyc, idle, (!m_v && m_cred == CRED)); end
            advance();
        end
        token = 1'b0;
        req_v = '0;
    endtask

    initial begin
        test_reset();
        test_credit_exhaust();
        test_round_robin();
        test_backpressure();
        test_simultaneous();
        test_overflow();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
